// File: rtl/hazard_if.sv
// Hazard controller signal bundle: pipeline-state inputs and stage-register controls.
interface hazard_if;
    logic        idex_memReadEnable;
    logic        idex_regWriteEnable;
    logic [2:0]  idex_regWriteNum;
    logic        idex_halt;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        ex_redirect;
    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        ifid_flush;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output idex_memReadEnable, idex_regWriteEnable, idex_regWriteNum, idex_halt,
               id_rs, id_rt, id_rs_used, id_rt_used, ex_redirect,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, stall_count, flush_count
    );

    modport slave (
        input  idex_memReadEnable, idex_regWriteEnable, idex_regWriteNum, idex_halt,
               id_rs, id_rt, id_rs_used, id_rt_used, ex_redirect,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and halt hold for PC/IF-ID/ID-EX.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hif
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic       hz_s;
    logic       pc_stall_s;
    logic       ifid_stall_s;
    logic       idex_bubble_s;
    logic       ifid_flush_s;

    assign hz_s = hif.idex_memReadEnable & hif.idex_regWriteEnable &
                  ((hif.id_rs_used & (hif.id_rs == hif.idex_regWriteNum)) |
                   (hif.id_rt_used & (hif.id_rt == hif.idex_regWriteNum)));

    // Next-state and Mealy control decode; priority halt > redirect > load-use.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_bubble_s = 1'b0;
        ifid_flush_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hif.idex_halt) begin
                    state_nxt_s   = ST_HALTED;
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (hif.ex_redirect) begin
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (hz_s) begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    cnt_nxt_s     = STALL_INIT;
                    state_nxt_s   = (STALL_INIT != 3'd0) ? ST_STALL : ST_RUN;
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            ST_STALL: begin
                if (hif.idex_halt) begin
                    state_nxt_s   = ST_HALTED;
                    cnt_nxt_s     = 3'd0;
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else if (hif.ex_redirect) begin
                    // Redirect squashes the stalled instruction, so release the stall now.
                    ifid_flush_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    cnt_nxt_s     = 3'd0;
                    state_nxt_s   = ST_RUN;
                end else begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                    cnt_nxt_s     = (cnt_r != 3'd0) ? (cnt_r - 3'd1) : 3'd0;
                    state_nxt_s   = (cnt_r <= 3'd1) ? ST_RUN : ST_STALL;
                end
            end
            ST_HALTED: begin
                pc_stall_s    = 1'b1;
                ifid_stall_s  = 1'b1;
                idex_bubble_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State and stall down-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Controls are forced low for as long as reset is held, independent of the clock.
    assign hif.pc_stall    = ~rst & pc_stall_s;
    assign hif.ifid_stall  = ~rst & ifid_stall_s;
    assign hif.idex_bubble = ~rst & idex_bubble_s;
    assign hif.ifid_flush  = ~rst & ifid_flush_s;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_r;
    logic [15:0] flush_count_r;

    // Saturating statistics; flush count is frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= 16'h0000;
            flush_count_r <= 16'h0000;
        end else begin
            if (pc_stall_s && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'h0001;
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (ifid_flush_s && (state_r != ST_HALTED) && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'h0001;
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign hif.stall_count = stall_count_r;
    assign hif.flush_count = flush_count_r;
`else
    assign hif.stall_count = 16'h0000;
    assign hif.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with N=1 and N=3 instances driven in lockstep.
module tb_hazard_ctrl;

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] ST = 4'b1110;   // {pc_stall, ifid_stall, idex_bubble, ifid_flush}
    localparam logic [3:0] FL = 4'b0011;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    hazard_if if1 ();
    hazard_if if3 ();

    hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .hif(if1));
    hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .hif(if3));

    wire [3:0] ctl1 = {if1.pc_stall, if1.ifid_stall, if1.idex_bubble, if1.ifid_flush};
    wire [3:0] ctl3 = {if3.pc_stall, if3.ifid_stall, if3.idex_bubble, if3.ifid_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sv(input logic [15:0] v);
        return STATS ? v : 16'h0000;
    endfunction

    task automatic drive(input logic mre, input logic rwe, input logic [2:0] wnum,
                         input logic [2:0] rs, input logic [2:0] rt, input logic rsu,
                         input logic rtu, input logic redir, input logic halt);
        if1.idex_memReadEnable = mre;  if3.idex_memReadEnable = mre;
        if1.idex_regWriteEnable = rwe; if3.idex_regWriteEnable = rwe;
        if1.idex_regWriteNum = wnum;   if3.idex_regWriteNum = wnum;
        if1.id_rs = rs;                if3.id_rs = rs;
        if1.id_rt = rt;                if3.id_rt = rt;
        if1.id_rs_used = rsu;          if3.id_rs_used = rsu;
        if1.id_rt_used = rtu;          if3.id_rt_used = rtu;
        if1.ex_redirect = redir;       if3.ex_redirect = redir;
        if1.idex_halt = halt;          if3.idex_halt = halt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle, then advances one edge.
    task automatic cyc(input string tag, input logic [3:0] e1, input logic [3:0] e3);
        #3;
        check_eq({tag, "_n1"}, {28'd0, ctl1}, {28'd0, e1});
        check_eq({tag, "_n3"}, {28'd0, ctl3}, {28'd0, e3});
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] s1, input logic [15:0] f1,
                                input logic [15:0] s3, input logic [15:0] f3);
        check_eq({tag, "_stall1"}, {16'd0, if1.stall_count}, {16'd0, sv(s1)});
        check_eq({tag, "_flush1"}, {16'd0, if1.flush_count}, {16'd0, sv(f1)});
        check_eq({tag, "_stall3"}, {16'd0, if3.stall_count}, {16'd0, sv(s3)});
        check_eq({tag, "_flush3"}, {16'd0, if3.flush_count}, {16'd0, sv(f3)});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        idle();
        #2;
        check_eq("rst_ctl1", {28'd0, ctl1}, 32'd0);
        check_eq("rst_ctl3", {28'd0, ctl3}, 32'd0);
        check_counts("rst", 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle();                                                              cyc("idle0", Z, Z);
        drive(1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);         cyc("lu_c0", ST, ST);
        idle();                                                              cyc("lu_c1", Z, ST);
        check_counts("after_lu1", 16'd1, 16'd0, 16'd2, 16'd0);
        idle();                                                              cyc("lu_c2", Z, ST);
        idle();                                                              cyc("lu_c3", Z, Z);
        check_counts("after_lu3", 16'd1, 16'd0, 16'd3, 16'd0);
        drive(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);         cyc("rt_unused", Z, Z);
        drive(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);         cyc("rt_used", ST, ST);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);         cyc("redir_stall", FL, FL);
        idle();                                                              cyc("post_redir", Z, Z);
        check_counts("after_redir", 16'd2, 16'd1, 16'd4, 16'd1);
        drive(1'b1, 1'b1, 3'd5, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);         cyc("hz_and_redir", FL, FL);
        idle();                                                              cyc("post_both", Z, Z);
        drive(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);         cyc("r0_c0", ST, ST);
        idle();                                                              cyc("r0_c1", Z, ST);
        idle();                                                              cyc("r0_c2", Z, ST);
        drive(1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);         cyc("no_load", Z, Z);
        check_counts("mid", 16'd3, 16'd2, 16'd7, 16'd2);

        // Reset asserted mid-stall, between clock edges.
        drive(1'b1, 1'b1, 3'd6, 3'd0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);         cyc("pre_rst", ST, ST);
        idle();
        #1;
        check_eq("in_stall3", {28'd0, ctl3}, {28'd0, ST});
        rst = 1'b1;
        #1;
        check_eq("rst_stall_ctl1", {28'd0, ctl1}, 32'd0);
        check_eq("rst_stall_ctl3", {28'd0, ctl3}, 32'd0);
        check_counts("rst_stall", 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();                                                              cyc("run_after_rst", Z, Z);

        // Halt wins over a simultaneous redirect and load-use hazard; held regardless of inputs.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);         cyc("flush_pre_halt", FL, FL);
        drive(1'b1, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, 1'b1, 3'd2, 3'd2, 3'd0, 1'b1, 1'b0, (i % 2 == 0), 1'b0);
            cyc("halted", ST, ST);
        end
        check_eq("halt_flush1", {16'd0, if1.flush_count}, {16'd0, sv(16'd1)});
        check_eq("halt_flush3", {16'd0, if3.flush_count}, {16'd0, sv(16'd1)});

        // Reset while halted.
        idle();
        rst = 1'b1;
        #1;
        check_eq("rst_halt_ctl1", {28'd0, ctl1}, 32'd0);
        check_eq("rst_halt_ctl3", {28'd0, ctl3}, 32'd0);
        check_counts("rst_halt", 16'd0, 16'd0, 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();                                                              cyc("run_after_halt", Z, Z);

        // Long halt drives stall_count into saturation.
        drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        idle();
        repeat (65540) @(posedge clk);
        #1;
        check_eq("sat_ctl1", {28'd0, ctl1}, {28'd0, ST});
        check_counts("sat", 16'hFFFF, 16'd0, 16'hFFFF, 16'd0);
        rst = 1'b1;
        #1;
        check_counts("rst_sat", 16'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
